// File: rtl/rr_select_pkg.sv
// Shared types and the round-robin scan helper for the registered N:1 select stage.
// The lock state type is only used when RR_SELECT_PKT_LOCK_EN is defined.
package rr_select_pkg;

    localparam int MAX_N      = 32;
    localparam int PICK_IDX_W = $clog2(MAX_N);

    typedef enum logic {IDLE, LOCKED} lock_state_e;

    typedef struct packed {
        logic                  found;
        logic [PICK_IDX_W-1:0] idx;
    } pick_t;

    // Scan valid[] from ptr upward, wrapping at n, and return the first set bit.
    function automatic pick_t rr_pick(input logic [MAX_N-1:0]      valid,
                                      input logic [PICK_IDX_W-1:0] ptr,
                                      input int unsigned           n);
        pick_t       r;
        logic [31:0] k;
        r = '0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            k = (32'(ptr) + i) % n;
            if (i < n && !r.found && valid[k[PICK_IDX_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = k[PICK_IDX_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_select_mux_stage_if.sv
// Stream-side and output-side bus of rr_select_mux_stage; in_last/out_last exist
// only when RR_SELECT_PKT_LOCK_EN is defined.
interface rr_select_mux_stage_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int SEL_W = $clog2(N);

    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [N-1:0][W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic [SEL_W-1:0]    out_sel;
`ifdef RR_SELECT_PKT_LOCK_EN
    logic [N-1:0]        in_last;
    logic                out_last;

    modport master (output in_valid, in_data, in_last, out_ready,
                    input  in_ready, out_valid, out_data, out_sel, out_last);
    modport slave  (input  in_valid, in_data, in_last, out_ready,
                    output in_ready, out_valid, out_data, out_sel, out_last);
`else
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_sel);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_sel);
`endif

endinterface

// File: rtl/rr_select_mux_stage_priority_pick.sv
// Combinational round-robin picker: rotate valid by ptr, find-first, rotate the
// index back into stream numbering.
module rr_priority_pick
    import rr_select_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [N-1:0] rotated;
    pick_t        first;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [SEL_W-1:0] src;
            assign src         = SEL_W'((gi + 32'(ptr)) % N);
            assign rotated[gi] = valid[src];
        end
    endgenerate

    // Position 0 of the rotated vector is the current highest-priority stream.
    assign first = rr_pick(MAX_N'(rotated), '0, N);
    assign found = first.found;
    assign idx   = SEL_W'((32'(first.idx) + 32'(ptr)) % N);

endmodule

// File: rtl/rr_select_mux_stage.sv
// Round-robin N:1 select stage with a single registered sel+data output word.
// Define RR_SELECT_PKT_LOCK_EN to hold the grant on one stream until in_last.
module rr_select_mux_stage
    import rr_select_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input logic            clk,
    input logic            rst,
    rr_select_mux_stage_if.slave bus
);

    localparam int SEL_W = $clog2(N);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;
    logic [N-1:0]     eligible;
    logic             found;
    logic [SEL_W-1:0] win;
    logic [SEL_W-1:0] next_ptr;
    logic             load;
    logic             fire;

    genvar gi;

`ifdef RR_SELECT_PKT_LOCK_EN
    lock_state_e      state_q,    state_d;
    logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
    logic             out_last_q, out_last_d;

    generate
        for (gi = 0; gi < N; gi++) begin : g_elig
            assign eligible[gi] = bus.in_valid[gi] &&
                                  (state_q == IDLE || lock_idx_q == SEL_W'(gi));
        end
    endgenerate
    assign bus.out_last = out_last_q;
`else
    assign eligible = bus.in_valid;
`endif

    rr_priority_pick #(.N(N), .SEL_W(SEL_W)) u_pick (
        .valid (eligible),
        .ptr   (ptr_q),
        .found (found),
        .idx   (win)
    );

    assign load     = !out_valid_q || bus.out_ready;
    assign fire     = !rst && load && found;
    assign next_ptr = (win == SEL_W'(N - 1)) ? '0 : win + SEL_W'(1);

    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign bus.in_ready[gi] = fire && (win == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
`ifdef RR_SELECT_PKT_LOCK_EN
        state_d     = state_q;
        lock_idx_d  = lock_idx_q;
        out_last_d  = out_last_q;
`endif
        // An empty load slot with nothing to take drains the register.
        if (load) begin
            out_valid_d = fire;
        end
        if (fire) begin
            out_data_d = bus.in_data[win];
            out_sel_d  = win;
`ifdef RR_SELECT_PKT_LOCK_EN
            out_last_d = bus.in_last[win];
            if (bus.in_last[win]) begin
                state_d = IDLE;
                ptr_d   = next_ptr;
            end else begin
                state_d    = LOCKED;
                lock_idx_d = win;
            end
`else
            ptr_d = next_ptr;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
`ifdef RR_SELECT_PKT_LOCK_EN
            state_q     <= IDLE;
            lock_idx_q  <= '0;
            out_last_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
`ifdef RR_SELECT_PKT_LOCK_EN
            state_q     <= state_d;
            lock_idx_q  <= lock_idx_d;
            out_last_q  <= out_last_d;
`endif
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule
